mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (M) stage of the 5-stage MIPS core: EX/MEM pipeline register plus the data-memory bus master. It captures the EX-stage results, performs byte/half/word loads and stores over a req/ack data-memory port, and presents RegWriteM, MemtoRegM, WriteRegM, ALUOutM and ReadDataM to the MEM/WB register. While an access is outstanding it raises StallM to the hazard unit and presents a bubble downstream.

## Interface
- ACK_TIMEOUT, default 0: BUSY cycles allowed before abort; 0 = no timeout; legal range 0-255.

- CLK  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  EX control (MemtoRegE=1 means load)
- MemSizeE  in  2  00 word, 01 half, 10 byte, 11 illegal
- LoadSignedE  in  1  sign-extend sub-word load
- WriteRegE  in  5  destination register
- ALUOutE  in  32  effective address / ALU result
- WriteDataE  in  32  store data (low bits significant)
- dm_req  out  1  access request
- dm_we  out  1  1 store, 0 load
- dm_addr  out  32  word address {ALUOutM[31:2],2'b00}
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  access complete (sampled on rising CLK)
- dm_rdata  in  32  load data, valid with dm_ack
- StallM  out  1  freeze IF/ID/EX
- RegWriteM, MemtoRegM  out  1 each  to MEM/WB
- WriteRegM  out  5; ALUOutM  out  32; ReadDataM  out  32  to MEM/WB
- AlignErrM  out  1  misaligned/illegal access in M
- BusErrM  out  1  access aborted by timeout

## Operation
- States: IDLE, BUSY. Reset: IDLE; all registers and every output 0.
- IDLE: StallM=0; at each rising edge the M register captures all E inputs. If captured op is a load or store and aligned, next state BUSY; otherwise stay IDLE.
- Alignment: word needs addr[1:0]=0, half needs addr[0]=0, byte always aligned; MemSize=11 illegal. Misaligned/illegal access: AlignErrM=1 for its single IDLE cycle in M, no dm_req, RegWriteM forced 0.
- BUSY: dm_req=1, StallM=1, RegWriteM forced 0 (bubble into MEM/WB); dm_we, dm_addr, dm_be, dm_wdata held stable until exit.
- dm_be: word 1111; half 0011<<(2*addr[1]); byte 0001<<addr[1:0]; driven for loads and stores.
- dm_wdata: word WriteData; half {2{WriteData[15:0]}}; byte {4{WriteData[7:0]}}.
- Edge with dm_ack=1 in BUSY: load extracts lane (byte by addr[1:0], half by addr[1]), sign- or zero-extends per LoadSigned into ReadDataM; go IDLE. Store: ReadDataM unchanged.
- Timeout (ACK_TIMEOUT=N>0): 8-bit counter of BUSY cycles, cleared on entry; if no ack sampled in the Nth BUSY cycle, go IDLE at that edge, BusErrM=1 for the following IDLE cycle, RegWriteM forced 0 then; ReadDataM unchanged.
- Outputs: RegWriteM = reg & ~BUSY & ~AlignErrM & ~BusErrM; MemtoRegM, WriteRegM, ALUOutM direct from M register; ReadDataM registered, updated only on load ack.
- dm_ack in IDLE ignored. ack and timeout on same edge: ack wins, BusErrM stays 0.

## Timing
- Non-memory op: captured at edge k, valid in M cycle k..k+1, taken by MEM/WB at edge k+1; throughput 1/cycle.
- Access with ack after w BUSY cycles (w>=1): M occupancy w+1 cycles; StallM high exactly w cycles; ReadDataM valid in the IDLE cycle after ack edge.
- Back-to-back accesses: second op captured at the exit edge of the first, dm_req returns high the next cycle (one idle bus cycle between requests).
- Reset asserted mid-BUSY: dm_req, StallM and all outputs fall to 0 immediately (asynchronous); transaction dropped; state IDLE on release.

## Test plan
- Reset: pull rst low in BUSY -> dm_req, StallM, RegWriteM, ALUOutM etc. 0 without a clock edge; after release no request until a new memory op.
- ALU op RegWriteE=1, WriteRegE=5, ALUOutE=0x00001234 -> next cycle RegWriteM=1, WriteRegM=5, ALUOutM=0x00001234, StallM=0, dm_req=0.
- Signed byte load addr 0x103, ack on 3rd BUSY cycle, dm_rdata=0x80FFFF7F -> dm_addr=0x100, dm_be=1000, StallM 3 cycles, ReadDataM=0xFFFFFF80, RegWriteM=1 only in following cycle; unsigned repeat -> 0x00000080.
- Half store addr 0x202, WriteDataE=0x0000ABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, stable until ack.
- Word load addr 0x006 -> AlignErrM=1 one cycle, dm_req never asserted, RegWriteM=0, StallM=0.
- ACK_TIMEOUT=4: no ack -> dm_req exactly 4 cycles, then BusErrM=1 one cycle, RegWriteM=0; rerun with ack in 4th BUSY cycle -> data taken, BusErrM=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the 5-stage MIPS core. Holds the EX/MEM pipeline
// register and acts as the data-memory bus master. Byte, half and word loads
// and stores go over a req/ack port. While an access is outstanding the stage
// stalls the front of the pipe and sends a bubble into MEM/WB.
//
// Ports
//   CLK, rst                    clock (rising edge), async active-low reset
//   RegWriteE .. WriteDataE     EX-stage results and controls, captured in IDLE
//   dm_req/dm_we/dm_addr/dm_be/dm_wdata   data-memory request, valid in BUSY
//   dm_ack, dm_rdata            data-memory completion and load data
//   StallM                      freezes IF/ID/EX while an access is in flight
//   RegWriteM .. ReadDataM      to the MEM/WB register
//   AlignErrM                   misaligned or illegal-size access in M
//   BusErrM                     access aborted by the ack timeout
// ---------------------------------------------------------------------------
module mem_access_stage #(
   parameter int unsigned ACK_TIMEOUT = 0  // BUSY cycles before abort, 0 = never
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic [1:0]  MemSizeE,
   input  logic        LoadSignedE,
   input  logic [4:0]  WriteRegE,
   input  logic [31:0] ALUOutE,
   input  logic [31:0] WriteDataE,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        StallM,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic [4:0]  WriteRegM,
   output logic [31:0] ALUOutM,
   output logic [31:0] ReadDataM,
   output logic        AlignErrM,
   output logic        BusErrM
);

   localparam bit         TmoEn    = (ACK_TIMEOUT != 0);
   localparam logic [7:0] TmoLimit = 8'(ACK_TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e      state_q, state_d;
   logic        reg_write_q;
   logic        mem_to_reg_q;
   logic        mem_write_q;
   logic [1:0]  mem_size_q;
   logic        load_signed_q;
   logic [4:0]  write_reg_q;
   logic [31:0] alu_out_q;
   logic [31:0] write_data_q;
   logic [31:0] read_data_q, read_data_d;
   logic        bus_err_q, bus_err_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;

   logic        capture;
   logic        busy;
   logic        align_err;
   logic        tmo_hit;
   logic [15:0] half_lane;
   logic [7:0]  byte_lane;
   logic [31:0] load_data;

   // Size 2'b11 is never a legal access.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (size)
         2'b00:   ok = (addr_lo == 2'b00);
         2'b01:   ok = ~addr_lo[0];
         2'b10:   ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign busy    = (state_q == StBusy);
   assign tmo_hit = TmoEn && (tmo_cnt_q == TmoLimit);

   // Next-state logic. The M register only loads in IDLE; during BUSY the
   // access fields must stay frozen so the bus sees stable request data.
   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      tmo_cnt_d   = tmo_cnt_q;
      bus_err_d   = 1'b0;
      read_data_d = read_data_q;
      case (state_q)
         StIdle: begin
            capture = 1'b1;
            if ((MemtoRegE | MemWriteE) && is_aligned(MemSizeE, ALUOutE[1:0])) begin
               state_d   = StBusy;
               tmo_cnt_d = 8'd0;
            end
         end
         StBusy: begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
            // An ack on the timeout edge still completes the access.
            if (dm_ack) begin
               state_d = StIdle;
               if (mem_to_reg_q) begin
                  read_data_d = load_data;
               end
            end else if (tmo_hit) begin
               state_d   = StIdle;
               bus_err_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Lane extraction for loads.
   always_comb begin
      half_lane = alu_out_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      byte_lane = dm_rdata[7:0];
      case (alu_out_q[1:0])
         2'b00:   byte_lane = dm_rdata[7:0];
         2'b01:   byte_lane = dm_rdata[15:8];
         2'b10:   byte_lane = dm_rdata[23:16];
         default: byte_lane = dm_rdata[31:24];
      endcase
      case (mem_size_q)
         2'b01:   load_data = {{16{load_signed_q & half_lane[15]}}, half_lane};
         2'b10:   load_data = {{24{load_signed_q & byte_lane[7]}}, byte_lane};
         default: load_data = dm_rdata;
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         reg_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_size_q    <= 2'b00;
         load_signed_q <= 1'b0;
         write_reg_q   <= 5'd0;
         alu_out_q     <= 32'd0;
         write_data_q  <= 32'd0;
         read_data_q   <= 32'd0;
         bus_err_q     <= 1'b0;
         tmo_cnt_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         read_data_q <= read_data_d;
         bus_err_q   <= bus_err_d;
         tmo_cnt_q   <= tmo_cnt_d;
         if (capture) begin
            reg_write_q   <= RegWriteE;
            mem_to_reg_q  <= MemtoRegE;
            mem_write_q   <= MemWriteE;
            mem_size_q    <= MemSizeE;
            load_signed_q <= LoadSignedE;
            write_reg_q   <= WriteRegE;
            alu_out_q     <= ALUOutE;
            write_data_q  <= WriteDataE;
         end
      end
   end

   // A misaligned op never leaves IDLE, so it is flagged for exactly one cycle.
   assign align_err = ~busy & (mem_to_reg_q | mem_write_q) &
                      ~is_aligned(mem_size_q, alu_out_q[1:0]);

   // Bus outputs are gated with BUSY so they read 0 whenever no access is live.
   always_comb begin
      dm_be    = 4'b0000;
      dm_wdata = 32'd0;
      if (busy) begin
         case (mem_size_q)
            2'b00: begin
               dm_be    = 4'b1111;
               dm_wdata = write_data_q;
            end
            2'b01: begin
               dm_be    = 4'b0011 << {alu_out_q[1], 1'b0};
               dm_wdata = {2{write_data_q[15:0]}};
            end
            2'b10: begin
               dm_be    = 4'b0001 << alu_out_q[1:0];
               dm_wdata = {4{write_data_q[7:0]}};
            end
            default: begin
               dm_be    = 4'b0000;
               dm_wdata = 32'd0;
            end
         endcase
      end
   end

   assign dm_req    = busy;
   assign dm_we     = busy & mem_write_q;
   assign dm_addr   = busy ? {alu_out_q[31:2], 2'b00} : 32'd0;
   assign StallM    = busy;
   assign RegWriteM = reg_write_q & ~busy & ~align_err & ~bus_err_q;
   assign MemtoRegM = mem_to_reg_q;
   assign WriteRegM = write_reg_q;
   assign ALUOutM   = alu_out_q;
   assign ReadDataM = read_data_q;
   assign AlignErrM = align_err;
   assign BusErrM   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage. Two instances share the stimulus:
// u0 has no ack timeout, u4 aborts after four BUSY cycles. A table of
// directed operations with hand-computed results drives u0; short hand-written
// sequences cover asynchronous reset mid-access and the timeout behaviour.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

   logic        CLK = 1'b0;
   logic        rst;
   logic        RegWriteE, MemtoRegE, MemWriteE, LoadSignedE;
   logic [1:0]  MemSizeE;
   logic [4:0]  WriteRegE;
   logic [31:0] ALUOutE, WriteDataE;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   logic        dm_req, dm_we, StallM, RegWriteM, MemtoRegM, AlignErrM, BusErrM;
   logic [31:0] dm_addr, dm_wdata, ALUOutM, ReadDataM;
   logic [3:0]  dm_be;
   logic [4:0]  WriteRegM;

   logic        dm_req4, dm_we4, StallM4, RegWriteM4, MemtoRegM4, AlignErrM4, BusErrM4;
   logic [31:0] dm_addr4, dm_wdata4, ALUOutM4, ReadDataM4;
   logic [3:0]  dm_be4;
   logic [4:0]  WriteRegM4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   mem_access_stage #(.ACK_TIMEOUT(0)) u0 (
      .CLK(CLK), .rst(rst),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .MemSizeE(MemSizeE), .LoadSignedE(LoadSignedE), .WriteRegE(WriteRegE),
      .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .StallM(StallM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
      .AlignErrM(AlignErrM), .BusErrM(BusErrM)
   );

   mem_access_stage #(.ACK_TIMEOUT(4)) u4 (
      .CLK(CLK), .rst(rst),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .MemSizeE(MemSizeE), .LoadSignedE(LoadSignedE), .WriteRegE(WriteRegE),
      .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
      .dm_req(dm_req4), .dm_we(dm_we4), .dm_addr(dm_addr4), .dm_be(dm_be4),
      .dm_wdata(dm_wdata4), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .StallM(StallM4), .RegWriteM(RegWriteM4), .MemtoRegM(MemtoRegM4),
      .WriteRegM(WriteRegM4), .ALUOutM(ALUOutM4), .ReadDataM(ReadDataM4),
      .AlignErrM(AlignErrM4), .BusErrM(BusErrM4)
   );

   typedef struct {
      logic        rw, mtr, mw;
      logic [1:0]  size;
      logic        sgn;
      logic [4:0]  wreg;
      logic [31:0] alu, wdata;
      int          wait_cyc;   // BUSY cycle carrying the ack
      logic [31:0] rdata;
      logic        busy;       // expected to issue a bus request
      logic [3:0]  be;
      logic [31:0] addr, dwdata;
      logic        exp_rw, exp_align;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tv[13];

   function automatic vec_t mk(
      input logic rw, input logic mtr, input logic mw, input logic [1:0] size,
      input logic sgn, input logic [4:0] wreg, input logic [31:0] alu,
      input logic [31:0] wdata, input int wait_cyc, input logic [31:0] rdata,
      input logic busy, input logic [3:0] be, input logic [31:0] addr,
      input logic [31:0] dwdata, input logic exp_rw, input logic exp_align,
      input logic [31:0] exp_rd);
      vec_t v;
      v.rw = rw; v.mtr = mtr; v.mw = mw; v.size = size; v.sgn = sgn; v.wreg = wreg;
      v.alu = alu; v.wdata = wdata; v.wait_cyc = wait_cyc; v.rdata = rdata;
      v.busy = busy; v.be = be; v.addr = addr; v.dwdata = dwdata;
      v.exp_rw = exp_rw; v.exp_align = exp_align; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_e(input logic rw, input logic mtr, input logic mw,
                          input logic [1:0] size, input logic sgn, input logic [4:0] wreg,
                          input logic [31:0] alu, input logic [31:0] wdata);
      RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw; MemSizeE = size;
      LoadSignedE = sgn; WriteRegE = wreg; ALUOutE = alu; WriteDataE = wdata;
   endtask

   task automatic nop_e();
      drive_e(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      nop_e();
      dm_ack = 1'b0;
      rst = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      rst = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge of the op's final M cycle.
   task automatic run_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("vec%0d", idx);
      drive_e(v.rw, v.mtr, v.mw, v.size, v.sgn, v.wreg, v.alu, v.wdata);
      // An ack while IDLE must be ignored.
      dm_ack   = !v.busy;
      dm_rdata = 32'hBAD0BAD0;
      @(negedge CLK);
      dm_ack = 1'b0;
      if (v.busy) begin
         for (int i = 1; i <= v.wait_cyc; i++) begin
            chk({p, " dm_req"},   32'(dm_req), 32'd1);
            chk({p, " StallM"},   32'(StallM), 32'd1);
            chk({p, " RegWriteM busy"}, 32'(RegWriteM), 32'd0);
            chk({p, " dm_we"},    32'(dm_we), 32'(v.mw));
            chk({p, " dm_addr"},  dm_addr, v.addr);
            chk({p, " dm_be"},    32'(dm_be), 32'(v.be));
            chk({p, " dm_wdata"}, dm_wdata, v.dwdata);
            dm_ack   = (i == v.wait_cyc);
            dm_rdata = (i == v.wait_cyc) ? v.rdata : 32'hBAD0BAD0;
            @(negedge CLK);
         end
         dm_ack = 1'b0;
      end
      chk({p, " dm_req idle"}, 32'(dm_req), 32'd0);
      chk({p, " StallM idle"}, 32'(StallM), 32'd0);
      chk({p, " RegWriteM"},   32'(RegWriteM), 32'(v.exp_rw));
      chk({p, " AlignErrM"},   32'(AlignErrM), 32'(v.exp_align));
      chk({p, " MemtoRegM"},   32'(MemtoRegM), 32'(v.mtr));
      chk({p, " WriteRegM"},   32'(WriteRegM), 32'(v.wreg));
      chk({p, " ALUOutM"},     ALUOutM, v.alu);
      chk({p, " ReadDataM"},   ReadDataM, v.exp_rd);
      chk({p, " BusErrM"},     32'(BusErrM), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      //        rw mtr mw size  sg wreg alu        wdata         w rdata
      //        busy be       addr        dwdata        erw eal exp_rd
      tv[0]  = mk(1, 0, 0, 2'b00, 0, 5,  32'h1234, 32'h0,        0, 32'h0,
                  0, 4'b0000, 32'h0,   32'h0,        1, 0, 32'h0);
      tv[1]  = mk(1, 1, 0, 2'b10, 1, 8,  32'h103,  32'h0,        3, 32'h80FFFF7F,
                  1, 4'b1000, 32'h100, 32'h0,        1, 0, 32'hFFFFFF80);
      tv[2]  = mk(1, 1, 0, 2'b10, 0, 9,  32'h103,  32'h0,        2, 32'h80FFFF7F,
                  1, 4'b1000, 32'h100, 32'h0,        1, 0, 32'h00000080);
      tv[3]  = mk(0, 0, 1, 2'b01, 0, 0,  32'h202,  32'h0000ABCD, 2, 32'h0,
                  1, 4'b1100, 32'h200, 32'hABCDABCD, 0, 0, 32'h00000080);
      tv[4]  = mk(1, 1, 0, 2'b00, 0, 10, 32'h006,  32'h0,        0, 32'h0,
                  0, 4'b0000, 32'h0,   32'h0,        0, 1, 32'h00000080);
      tv[5]  = mk(1, 1, 0, 2'b00, 0, 11, 32'h40,   32'h0,        1, 32'hDEADBEEF,
                  1, 4'b1111, 32'h40,  32'h0,        1, 0, 32'hDEADBEEF);
      tv[6]  = mk(1, 1, 0, 2'b01, 1, 12, 32'h12,   32'h0,        1, 32'h80017FFF,
                  1, 4'b1100, 32'h10,  32'h0,        1, 0, 32'hFFFF8001);
      tv[7]  = mk(1, 1, 0, 2'b01, 0, 13, 32'h10,   32'h0,        2, 32'h1234F00D,
                  1, 4'b0011, 32'h10,  32'h0,        1, 0, 32'h0000F00D);
      tv[8]  = mk(0, 0, 1, 2'b10, 0, 0,  32'h21,   32'h123456A5, 1, 32'h0,
                  1, 4'b0010, 32'h20,  32'hA5A5A5A5, 0, 0, 32'h0000F00D);
      tv[9]  = mk(1, 1, 0, 2'b11, 0, 14, 32'h0,    32'h0,        0, 32'h0,
                  0, 4'b0000, 32'h0,   32'h0,        0, 1, 32'h0000F00D);
      tv[10] = mk(1, 1, 0, 2'b10, 0, 15, 32'h1,    32'h0,        3, 32'h0000C300,
                  1, 4'b0010, 32'h0,   32'h0,        1, 0, 32'h000000C3);
      tv[11] = mk(0, 0, 1, 2'b00, 0, 0,  32'h80,   32'hCAFEF00D, 1, 32'h0,
                  1, 4'b1111, 32'h80,  32'hCAFEF00D, 0, 0, 32'h000000C3);
      tv[12] = mk(0, 0, 1, 2'b01, 0, 0,  32'h1,    32'h5555,     0, 32'h0,
                  0, 4'b0000, 32'h0,   32'h0,        0, 1, 32'h000000C3);

      // Reset state, checked before any clock edge.
      nop_e();
      dm_ack = 1'b0;
      dm_rdata = 32'h0;
      rst = 1'b0;
      #1;
      chk("reset dm_req",    32'(dm_req), 32'd0);
      chk("reset dm_be",     32'(dm_be), 32'd0);
      chk("reset dm_addr",   dm_addr, 32'd0);
      chk("reset StallM",    32'(StallM), 32'd0);
      chk("reset RegWriteM", 32'(RegWriteM), 32'd0);
      chk("reset ALUOutM",   ALUOutM, 32'd0);
      chk("reset ReadDataM", ReadDataM, 32'd0);
      chk("reset AlignErrM", 32'(AlignErrM), 32'd0);
      chk("reset BusErrM",   32'(BusErrM), 32'd0);
      @(negedge CLK);
      rst = 1'b1;

      // Back-to-back table: each op is driven in the previous op's last M cycle.
      foreach (tv[i]) run_vec(tv[i], i);
      nop_e();
      @(negedge CLK);

      // Asynchronous reset while BUSY.
      drive_e(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd7, 32'h333, 32'h0);
      @(negedge CLK);
      nop_e();
      chk("midbusy dm_req before", 32'(dm_req), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("midbusy dm_req",    32'(dm_req), 32'd0);
      chk("midbusy StallM",    32'(StallM), 32'd0);
      chk("midbusy ALUOutM",   ALUOutM, 32'd0);
      chk("midbusy WriteRegM", 32'(WriteRegM), 32'd0);
      chk("midbusy dm_be",     32'(dm_be), 32'd0);
      chk("midbusy ReadDataM", ReadDataM, 32'd0);
      @(negedge CLK);
      rst = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("post-reset dm_req", 32'(dm_req), 32'd0);
         chk("post-reset StallM", 32'(StallM), 32'd0);
      end

      // Timeout on u4: no ack.
      do_reset();
      drive_e(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd3, 32'h40, 32'h0);
      @(negedge CLK);
      nop_e();
      cnt = 0;
      for (int i = 0; i < 10 && dm_req4; i++) begin
         cnt++;
         @(negedge CLK);
      end
      chk("timeout req cycles", 32'(cnt), 32'd4);
      chk("timeout BusErrM",    32'(BusErrM4), 32'd1);
      chk("timeout RegWriteM",  32'(RegWriteM4), 32'd0);
      chk("timeout StallM",     32'(StallM4), 32'd0);
      chk("timeout ReadDataM",  ReadDataM4, 32'd0);
      @(negedge CLK);
      chk("timeout BusErrM clears", 32'(BusErrM4), 32'd0);

      // Ack in the 4th BUSY cycle wins over the timeout.
      do_reset();
      drive_e(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd4, 32'h44, 32'h0);
      @(negedge CLK);
      nop_e();
      for (int i = 1; i <= 4; i++) begin
         chk("late-ack dm_req", 32'(dm_req4), 32'd1);
         dm_ack   = (i == 4);
         dm_rdata = (i == 4) ? 32'h11223344 : 32'hBAD0BAD0;
         @(negedge CLK);
      end
      dm_ack = 1'b0;
      chk("late-ack BusErrM",   32'(BusErrM4), 32'd0);
      chk("late-ack ReadDataM", ReadDataM4, 32'h11223344);
      chk("late-ack RegWriteM", 32'(RegWriteM4), 32'd1);
      chk("late-ack StallM",    32'(StallM4), 32'd0);
      chk("late-ack WriteRegM", 32'(WriteRegM4), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
